// File: rtl/key_set_pkg.sv
// Shared types and field limits for the time/alarm setting controller.
package key_set_pkg;

  localparam int unsigned HOUR_W   = 5;
  localparam int unsigned MIN_W    = 6;
  localparam int unsigned HOUR_MAX = 23;
  localparam int unsigned MIN_MAX  = 59;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StTHour = 3'd1,
    StTMin  = 3'd2,
    StAHour = 3'd3,
    StAMin  = 3'd4
  } state_e;

  function automatic logic is_edit(state_e s);
    return (s == StTHour) || (s == StTMin) || (s == StAHour) || (s == StAMin);
  endfunction

endpackage

// File: rtl/wrap_updown.sv
// Registered up/down counter over 0..MAX with wrap-around and synchronous load.
module wrap_updown #(
  parameter int unsigned MAX   = 23,
  parameter int unsigned WIDTH = 5
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             up_i,
  input  logic             down_i,
  output logic [WIDTH-1:0] cnt_o
);

  localparam logic [WIDTH-1:0] Max = WIDTH'(MAX);

  logic [WIDTH-1:0] cnt_d, cnt_q;

  // Load beats up, up beats down.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (up_i) begin
      cnt_d = (cnt_q >= Max) ? '0 : cnt_q + 1'b1;
    end else if (down_i) begin
      cnt_d = (cnt_q == '0) ? Max : cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/key_set_ctrl.sv
// Time/alarm setting state machine driven by debounced mode/up/down key pulses.
module key_set_ctrl
  import key_set_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 500_000_000,
  parameter int unsigned BLINK_CYC   = 12_500_000
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              key_mode_i,
  input  logic              key_up_i,
  input  logic              key_down_i,
  input  logic [HOUR_W-1:0] cur_hour_i,
  input  logic [MIN_W-1:0]  cur_min_i,
  output logic [2:0]        edit_sel_o,
  output logic [HOUR_W-1:0] edit_hour_o,
  output logic [MIN_W-1:0]  edit_min_o,
  output logic              blink_o,
  output logic              time_load_o,
  output logic [HOUR_W-1:0] alarm_hour_o,
  output logic [MIN_W-1:0]  alarm_min_o,
  output logic              alarm_en_o
);

  localparam int unsigned     TmoW    = $clog2(TIMEOUT_CYC);
  localparam int unsigned     BlkW    = $clog2(BLINK_CYC);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYC - 1);
  localparam logic [BlkW-1:0] BlkLast = BlkW'(BLINK_CYC - 1);

  state_e            state_d, state_q;
  logic              time_load_d, time_load_q;
  logic [HOUR_W-1:0] alarm_hour_d, alarm_hour_q;
  logic [MIN_W-1:0]  alarm_min_d, alarm_min_q;
  logic              alarm_en_d, alarm_en_q;
  logic              blink_d, blink_q;
  logic [TmoW-1:0]   tmo_d, tmo_q, tmo_inc;
  logic [BlkW-1:0]   blk_d, blk_q;

  logic              up_p, dn_p, any_key;
  logic              fld_load;
  logic              hr_up, hr_dn, min_up, min_dn;
  logic [HOUR_W-1:0] hr_load_val, edit_hour;
  logic [MIN_W-1:0]  min_load_val, edit_min;

  assign up_p    = key_up_i & ~key_mode_i;
  assign dn_p    = key_down_i & ~key_mode_i & ~key_up_i;
  assign any_key = key_mode_i | key_up_i | key_down_i;
  assign tmo_inc = tmo_q + 1'b1;

  // Alarm reload is deferred one cycle so the committed time is still visible with time_load.
  assign hr_load_val  = time_load_q ? alarm_hour_q : cur_hour_i;
  assign min_load_val = time_load_q ? alarm_min_q : cur_min_i;

  always_comb begin
    state_d      = state_q;
    time_load_d  = 1'b0;
    alarm_hour_d = alarm_hour_q;
    alarm_min_d  = alarm_min_q;
    alarm_en_d   = alarm_en_q;
    fld_load     = time_load_q;
    hr_up        = 1'b0;
    hr_dn        = 1'b0;
    min_up       = 1'b0;
    min_dn       = 1'b0;

    case (state_q)
      StIdle: begin
        if (key_mode_i) begin
          state_d  = StTHour;
          fld_load = 1'b1;
        end else if (up_p || dn_p) begin
          alarm_en_d = ~alarm_en_q;
        end
      end
      StTHour, StAHour: begin
        if (key_mode_i) begin
          state_d = (state_q == StTHour) ? StTMin : StAMin;
        end else begin
          hr_up = up_p;
          hr_dn = dn_p;
        end
      end
      StTMin: begin
        if (key_mode_i) begin
          time_load_d = 1'b1;
          state_d     = StAHour;
        end else begin
          min_up = up_p;
          min_dn = dn_p;
        end
      end
      StAMin: begin
        if (key_mode_i) begin
          alarm_hour_d = edit_hour;
          alarm_min_d  = edit_min;
          alarm_en_d   = 1'b1;
          state_d      = StIdle;
        end else begin
          min_up = up_p;
          min_dn = dn_p;
        end
      end
      default: state_d = StIdle;
    endcase

    // Abort on the cycle the idle count would reach TIMEOUT_CYC-1; a key always wins.
    tmo_d = '0;
    if (is_edit(state_q) && !any_key) begin
      if (tmo_inc == TmoLast) begin
        state_d = StIdle;
      end else begin
        tmo_d = tmo_inc;
      end
    end

    blk_d   = '0;
    blink_d = 1'b0;
    if (is_edit(state_d)) begin
      if (any_key) begin
        blink_d = 1'b1;
      end else if (blk_q == BlkLast) begin
        blink_d = ~blink_q;
      end else begin
        blk_d   = blk_q + 1'b1;
        blink_d = blink_q;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      time_load_q  <= 1'b0;
      alarm_hour_q <= '0;
      alarm_min_q  <= '0;
      alarm_en_q   <= 1'b0;
      blink_q      <= 1'b0;
      tmo_q        <= '0;
      blk_q        <= '0;
    end else begin
      state_q      <= state_d;
      time_load_q  <= time_load_d;
      alarm_hour_q <= alarm_hour_d;
      alarm_min_q  <= alarm_min_d;
      alarm_en_q   <= alarm_en_d;
      blink_q      <= blink_d;
      tmo_q        <= tmo_d;
      blk_q        <= blk_d;
    end
  end

  wrap_updown #(
    .MAX  (HOUR_MAX),
    .WIDTH(HOUR_W)
  ) u_hour (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .load_i    (fld_load),
    .load_val_i(hr_load_val),
    .up_i      (hr_up),
    .down_i    (hr_dn),
    .cnt_o     (edit_hour)
  );

  wrap_updown #(
    .MAX  (MIN_MAX),
    .WIDTH(MIN_W)
  ) u_min (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .load_i    (fld_load),
    .load_val_i(min_load_val),
    .up_i      (min_up),
    .down_i    (min_dn),
    .cnt_o     (edit_min)
  );

  assign edit_sel_o   = state_q;
  assign edit_hour_o  = edit_hour;
  assign edit_min_o   = edit_min;
  assign blink_o      = blink_q;
  assign time_load_o  = time_load_q;
  assign alarm_hour_o = alarm_hour_q;
  assign alarm_min_o  = alarm_min_q;
  assign alarm_en_o   = alarm_en_q;

endmodule

// File: tb/tb_key_set_ctrl.sv
// Self-checking bench for key_set_ctrl: vector table, directed corner cases, random vs model.
module tb_key_set_ctrl;

  localparam int TMO = 100;
  localparam int BLK = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_mode, key_up, key_down;
  logic [4:0] cur_hour;
  logic [5:0] cur_min;
  logic [2:0] edit_sel;
  logic [4:0] edit_hour, alarm_hour;
  logic [5:0] edit_min, alarm_min;
  logic       blink, time_load, alarm_en;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural reference state
  int m_state, m_hour, m_min, m_ahour, m_amin, m_en, m_blink, m_tl;
  int m_idle, m_bage;

  always #5 clk = ~clk;

  key_set_ctrl #(
    .TIMEOUT_CYC(TMO),
    .BLINK_CYC  (BLK)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .key_mode_i  (key_mode),
    .key_up_i    (key_up),
    .key_down_i  (key_down),
    .cur_hour_i  (cur_hour),
    .cur_min_i   (cur_min),
    .edit_sel_o  (edit_sel),
    .edit_hour_o (edit_hour),
    .edit_min_o  (edit_min),
    .blink_o     (blink),
    .time_load_o (time_load),
    .alarm_hour_o(alarm_hour),
    .alarm_min_o (alarm_min),
    .alarm_en_o  (alarm_en)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_step(input bit rst, input bit m, input bit u, input bit d,
                                     input int ch, input int cm);
    int key, ns;
    bit was_tl;
    if (!rst) begin
      m_state = 0; m_hour = 0; m_min = 0; m_ahour = 0; m_amin = 0;
      m_en = 0; m_blink = 0; m_tl = 0; m_idle = 0; m_bage = 0;
      return;
    end
    key    = m ? 1 : (u ? 2 : (d ? 3 : 0));
    was_tl = (m_tl != 0);
    m_tl   = 0;
    ns     = m_state;
    case (m_state)
      0: begin
        if (key == 1) begin ns = 1; m_hour = ch; m_min = cm; end
        else if (key != 0) m_en = 1 - m_en;
      end
      1, 3: begin
        if (key == 1) ns = m_state + 1;
        else if (key == 2) m_hour = (m_hour + 1) % 24;
        else if (key == 3) m_hour = (m_hour + 23) % 24;
      end
      2, 4: begin
        if (key == 1) begin
          if (m_state == 2) begin m_tl = 1; ns = 3; end
          else begin m_ahour = m_hour; m_amin = m_min; m_en = 1; ns = 0; end
        end
        else if (key == 2) m_min = (m_min + 1) % 60;
        else if (key == 3) m_min = (m_min + 59) % 60;
      end
      default: ns = 0;
    endcase
    if (was_tl) begin m_hour = m_ahour; m_min = m_amin; end
    if (m_state >= 1 && m_state <= 4) begin
      if (key != 0) m_idle = 0;
      else begin
        m_idle++;
        if (m_idle == TMO - 1) begin ns = 0; m_idle = 0; end
      end
    end else m_idle = 0;
    if (ns == 0) begin m_blink = 0; m_bage = 0; end
    else if (key != 0) begin m_blink = 1; m_bage = 0; end
    else begin
      m_bage++;
      if (m_bage == BLK) begin m_blink = 1 - m_blink; m_bage = 0; end
    end
    m_state = ns;
  endfunction

  task automatic chk_model();
    chk("model.edit_sel", edit_sel, m_state);
    chk("model.edit_hour", edit_hour, m_hour);
    chk("model.edit_min", edit_min, m_min);
    chk("model.blink", blink, m_blink);
    chk("model.time_load", time_load, m_tl);
    chk("model.alarm_hour", alarm_hour, m_ahour);
    chk("model.alarm_min", alarm_min, m_amin);
    chk("model.alarm_en", alarm_en, m_en);
  endtask

  // Apply one cycle of inputs, then sample 1 time unit after the edge.
  task automatic step(input bit m, input bit u, input bit d);
    key_mode = m; key_up = u; key_down = d;
    @(posedge clk);
    #1;
    model_step(rst_n, m, u, d, int'(cur_hour), int'(cur_min));
    key_mode = 0; key_up = 0; key_down = 0;
    chk_model();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0);
  endtask

  task automatic do_reset();
    rst_n = 0;
    step(0, 0, 0);
    rst_n = 1;
  endtask

  typedef struct packed {
    bit        m, u, d;
    bit [5:0]  rep;
    bit [2:0]  sel;
    bit [4:0]  hour;
    bit [5:0]  mn;
    bit        tl;
  } vec_t;

  vec_t tbl[$];

  initial begin
    rst_n = 0; key_mode = 0; key_up = 0; key_down = 0;
    cur_hour = 5'd10; cur_min = 6'd30;
    do_reset();
    chk("reset.edit_sel", edit_sel, 0);
    chk("reset.blink", blink, 0);
    chk("reset.alarm_en", alarm_en, 0);
    chk("reset.time_load", time_load, 0);

    // Set time 10:30 -> 13:59 and commit
    tbl.push_back('{m: 1, u: 0, d: 0, rep: 1,  sel: 1, hour: 10, mn: 30, tl: 0});
    tbl.push_back('{m: 0, u: 1, d: 0, rep: 3,  sel: 1, hour: 13, mn: 30, tl: 0});
    tbl.push_back('{m: 1, u: 0, d: 0, rep: 1,  sel: 2, hour: 13, mn: 30, tl: 0});
    tbl.push_back('{m: 0, u: 0, d: 1, rep: 31, sel: 2, hour: 13, mn: 59, tl: 0});
    tbl.push_back('{m: 1, u: 0, d: 0, rep: 1,  sel: 3, hour: 13, mn: 59, tl: 1});
    tbl.push_back('{m: 0, u: 0, d: 0, rep: 1,  sel: 3, hour: 0,  mn: 0,  tl: 0});
    foreach (tbl[i]) begin
      for (int r = 0; r < int'(tbl[i].rep); r++) step(tbl[i].m, tbl[i].u, tbl[i].d);
      chk($sformatf("vec%0d.sel", i), edit_sel, tbl[i].sel);
      chk($sformatf("vec%0d.hour", i), edit_hour, tbl[i].hour);
      chk($sformatf("vec%0d.min", i), edit_min, tbl[i].mn);
      chk($sformatf("vec%0d.time_load", i), time_load, tbl[i].tl);
    end

    // Alarm commit from A_HOUR at 0/0
    step(0, 0, 1);
    chk("alarm.hour_wrap", edit_hour, 23);
    step(1, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 0);
    step(1, 0, 0);
    chk("alarm.hour", alarm_hour, 23);
    chk("alarm.min", alarm_min, 5);
    chk("alarm.en", alarm_en, 1);
    chk("alarm.sel", edit_sel, 0);
    chk("alarm.no_load", time_load, 0);

    // Reset in A_MIN discards everything
    step(1, 0, 0); step(1, 0, 0); step(1, 0, 0); step(0, 0, 0); step(1, 0, 0);
    step(0, 1, 0);
    chk("amin.sel", edit_sel, 4);
    do_reset();
    chk("rst_amin.sel", edit_sel, 0);
    chk("rst_amin.hour", edit_hour, 0);
    chk("rst_amin.min", edit_min, 0);
    chk("rst_amin.alarm_hour", alarm_hour, 0);
    chk("rst_amin.alarm_min", alarm_min, 0);
    chk("rst_amin.alarm_en", alarm_en, 0);
    chk("rst_amin.blink", blink, 0);

    // Field wraps
    cur_hour = 5'd23; cur_min = 6'd0;
    step(1, 0, 0);
    step(0, 1, 0);
    chk("wrap.hour_up", edit_hour, 0);
    step(1, 0, 0);
    step(0, 0, 1);
    chk("wrap.min_down", edit_min, 59);

    // Timeout, with a key at idle cycle 98 restarting the count
    do_reset();
    step(1, 0, 0);
    idle(97);
    step(0, 1, 0);
    idle(98);
    chk("tmo.restart_sel", edit_sel, 1);
    step(0, 0, 0);
    chk("tmo.sel", edit_sel, 0);
    chk("tmo.no_load", time_load, 0);
    chk("tmo.blink", blink, 0);
    chk("tmo.alarm_en", alarm_en, 0);

    // Priority and alarm_en toggle
    do_reset();
    step(1, 1, 0);
    chk("prio.sel", edit_sel, 1);
    chk("prio.alarm_en", alarm_en, 0);
    do_reset();
    step(0, 1, 0);
    chk("toggle1", alarm_en, 1);
    step(0, 1, 0);
    chk("toggle2", alarm_en, 0);

    // Blink phase in T_HOUR
    step(1, 0, 0);
    chk("blink.enter", blink, 1);
    idle(3);
    chk("blink.hold", blink, 1);
    step(0, 0, 0);
    chk("blink.off", blink, 0);
    idle(4);
    chk("blink.on", blink, 1);
    idle(4);
    chk("blink.off2", blink, 0);
    step(0, 1, 0);
    chk("blink.key", blink, 1);
    idle(3);
    chk("blink.restart_hold", blink, 1);
    step(0, 0, 0);
    chk("blink.restart_off", blink, 0);

    // Randomised traffic against the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      int dens;
      dens = ((i / 400) % 2 == 0) ? 4 : 200;
      if (($urandom % 16) == 0) begin
        cur_hour = 5'($urandom_range(0, 23));
        cur_min  = 6'($urandom_range(0, 59));
      end
      rst_n = (($urandom % 700) != 0);
      step(($urandom % dens) == 0, ($urandom % dens) == 0, ($urandom % dens) == 0);
      rst_n = 1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
